io_bus_responder: RTL and testbench

Memory-mapped I/O responder on the RiscV core's data-memory port, serving the I/O side of the load/store interface. It decodes I/O-space accesses, holds the LED register, and feeds a byte-wide transmit FIFO drained by a UART transmitter. Read data returns combinationally from registered state in the same cycle, as the single-cycle core requires; all state changes happen on the clock edge.

---
 rtl/io_bus_responder_pkg.sv | 23 ++
 rtl/io_bus_responder_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 48 ++++
 rtl/io_bus_responder.sv | 138 +++++++++++++
 tb/tb_io_bus_responder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/io_bus_responder_pkg.sv
// Shared constants and types for the RISC-V I/O responder: register map,
// status bit layout and the UART transmit state encoding.
package riscv_io_pkg;

    localparam int IO_SEL_BIT = 22;

    localparam logic [1:0] LEDS_OFF        = 2'd0;
    localparam logic [1:0] UART_DATA_OFF   = 2'd1;
    localparam logic [1:0] UART_STATUS_OFF = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_BUSY    = 1;
    localparam int ST_CNT_LSB = 2;
    localparam int ST_OVF     = 5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // Status reports at most 7 entries even for deeper FIFOs.
    function automatic logic [2:0] sat3(input logic [31:0] c);
        return (c > 32'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/io_bus_responder_if.sv
// Core data-memory port as seen by the I/O responder.
interface io_bus_if;
    logic [31:0] addr;
    logic [31:0] memWdata;
    logic [3:0]  memWMask;
    logic [31:0] ioRdata;
    logic        ioSel;

    modport master (output addr, memWdata, memWMask, input ioRdata, ioSel);
    modport slave  (input addr, memWdata, memWMask, output ioRdata, ioSel);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: LED register, UART TX FIFO and an 8N1
// transmitter. Read data is combinational from registered state.
module io_bus_responder
    import riscv_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    io_bus_if.slave    bus,
    output logic [4:0] leds,
    output logic       uartTxd
);
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCW-1:0] BAUD_LOAD = BCW'(CLKS_PER_BIT - 1);

    logic [1:0]     off;
    logic           wr, push_req, pop;
    logic           full, empty;
    logic [FCW-1:0] count;
    logic [7:0]     fifo_dout;
    logic [5:0]     status;
    logic [31:0]    rdata;

    logic [4:0]     leds_q, leds_d;
    logic           ovf_q, ovf_d;
    tx_state_t      state_q;
    logic [BCW-1:0] baud_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic           txd_q;

    assign bus.ioSel = bus.addr[IO_SEL_BIT];
    assign off       = bus.addr[3:2];
    assign wr        = bus.ioSel & bus.memWMask[0];
    assign push_req  = wr && (off == UART_DATA_OFF);
    assign pop       = (state_q == IDLE) && !empty;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .din_i   (bus.memWdata[7:0]),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        leds_d = leds_q;
        ovf_d  = ovf_q;
        if (wr && off == LEDS_OFF) leds_d = bus.memWdata[4:0];
        // A coinciding pop frees a slot, so only a true full drop is sticky.
        if (push_req && full && !pop) ovf_d = 1'b1;
        if (wr && off == UART_STATUS_OFF) ovf_d = 1'b0;
    end

    always_comb begin
        status                       = '0;
        status[ST_FULL]              = full;
        status[ST_BUSY]              = (state_q != IDLE);
        status[ST_CNT_LSB +: 3]      = sat3(32'(count));
        status[ST_OVF]               = ovf_q;
        rdata = '0;
        if (bus.ioSel) begin
            case (off)
                LEDS_OFF:        rdata = {27'b0, leds_q};
                UART_STATUS_OFF: rdata = {26'b0, status};
                default:         rdata = '0;
            endcase
        end
    end

    assign bus.ioRdata = rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q  <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            leds_q <= leds_d;
            ovf_q  <= ovf_d;
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_dout;
                        baud_q  <= BAUD_LOAD;
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_q == '0) begin
                        baud_q  <= BAUD_LOAD;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= BAUD_LOAD;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 1'b1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_q == '0) state_q <= IDLE;
                    else              baud_q  <= baud_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign leds    = leds_q;
    assign uartTxd = txd_q;
endmodule

// File: tb/tb_io_bus_responder.sv
// Randomized bench for io_bus_responder against a time-based model of the
// register map, TX queue and serial line.
module tb_io_bus_responder;
    localparam int C     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] leds;
    logic       uartTxd;
    int         n_chk = 0;
    int         n_err = 0;

    io_bus_if bus ();

    io_bus_responder #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .leds    (leds),
        .uartTxd (uartTxd)
    );

    always #5 clk = ~clk;

    // Model: queued bytes, and the frame in flight as "cycles since pop".
    logic [7:0] m_q[$];
    bit         m_active;
    int         m_t;
    logic [7:0] m_cur;
    logic       m_ovf;
    logic [4:0] m_leds;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 0;
        m_t      = 0;
        m_cur    = '0;
        m_ovf    = 0;
        m_leds   = '0;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bit wr;
        logic [1:0] off;
        wr  = a[22] && m[0];
        off = a[3:2];
        if (m_active) begin
            m_t++;
            if (m_t == 10 * C) m_active = 0;
        end else if (m_q.size() > 0) begin
            m_cur    = m_q.pop_front();
            m_active = 1;
            m_t      = 0;
        end
        if (wr) begin
            case (off)
                2'd0: m_leds = d[4:0];
                2'd1: if (m_q.size() < DEPTH) m_q.push_back(d[7:0]); else m_ovf = 1;
                2'd2: m_ovf = 0;
                default: ;
            endcase
        end
    endtask

    function automatic logic exp_txd();
        if (!m_active)   return 1'b1;
        if (m_t < C)     return 1'b0;
        if (m_t < 9 * C) return m_cur[(m_t - C) / C];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [2:0] n;
        logic [1:0] off;
        n   = (m_q.size() > 7) ? 3'd7 : 3'(m_q.size());
        off = a[3:2];
        case (off)
            2'd0:    return {27'b0, m_leds};
            2'd2:    return {26'b0, m_ovf, n, 1'(m_active), 1'(m_q.size() == DEPTH)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        bus.addr     = a;
        bus.memWdata = d;
        bus.memWMask = m;
        #1;
        chk("iosel", 32'(bus.ioSel), 32'(a[22]));
        if (a[22]) chk("rdata", bus.ioRdata, exp_rd(a));
        @(posedge clk);
        model_edge(a, d, m);
        #1;
        chk("txd", 32'(uartTxd), 32'(exp_txd()));
        chk("leds", 32'(leds), 32'(m_leds));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0040_0008, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.addr     = 32'h0040_0008;
        bus.memWdata = 32'h0;
        bus.memWMask = 4'h0;
        reset        = 1'b1;
        #1;
        chk("rst_txd", 32'(uartTxd), 32'h1);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_status", bus.ioRdata, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.addr     = 32'h0;
        bus.memWdata = 32'h0;
        bus.memWMask = 4'h0;
        model_reset();
        do_reset();
        idle(2);

        // LED register and upper-strobe-only store
        step(32'h0040_0000, 32'h0000_000E, 4'b0001);
        chk("led_val", 32'(leds), 32'h0E);
        step(32'h0040_0000, 32'h0, 4'b0000);
        step(32'h0040_0000, 32'h0000_001F, 4'b0010);
        chk("led_mask", 32'(leds), 32'h0E);

        // Single frame of 0x55
        step(32'h0040_0004, 32'h55, 4'b0001);
        step(32'h0040_0008, 32'h0, 4'h0);
        chk("start_bit", 32'(uartTxd), 32'h0);
        idle(10 * C + 4);

        // Burst of six: one in flight, four buffered, one dropped
        for (int i = 0; i < 6; i++) step(32'h0040_0004, 32'h41 + 32'(i), 4'b0001);
        step(32'h0040_0008, 32'h0, 4'h0);
        chk("six_status", bus.ioRdata, 32'h33);
        step(32'h0040_0008, 32'h0, 4'b0001);
        chk("ovf_clr", bus.ioRdata, 32'h13);
        idle(5 * (10 * C + 1) + 8);

        // Reset during the third data bit
        step(32'h0040_0004, 32'hA7, 4'b0001);
        idle(14);
        do_reset();
        idle(12 * C);

        // Non-I/O store and reserved offset
        step(32'h0000_0036, 32'hFFFF_FFFF, 4'hF);
        step(32'h0040_000C, 32'hFFFF_FFFF, 4'hF);
        step(32'h0040_000C, 32'h0, 4'h0);
        chk("rsvd_rd", bus.ioRdata, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [31:0] a, d;
            logic [3:0]  m;
            r = $urandom_range(0, 99);
            d = $urandom();
            m = 4'($urandom_range(1, 15));
            if (r < 5)       a = 32'h0040_0004;
            else if (r < 8)  a = 32'h0040_0000;
            else if (r < 10) a = 32'h0040_0008;
            else if (r < 12) a = 32'h0040_000C;
            else if (r < 14) a = $urandom() & ~32'h0040_0000;
            else begin
                a = 32'h0040_0000 | (32'($urandom_range(0, 3)) << 2);
                m = 4'h0;
            end
            if (i == 1500) do_reset();
            step(a, d, m);
        end
        idle(6 * (10 * C + 1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
